// File: rtl/mem_io_responder.sv
// Memory/IO responder: a byte RAM plus a small IO window (UART RX/TX byte
// FIFOs, a free-running cycle counter with snapshot, and a program-done flag).
// IO window is a_in[17:16] == 2'b11, decoded on a_in[15:0]:
//   read  0x0000 : pop one RX byte (0x00 when empty)
//   read  0x0004 : snapshot cycle counter, return byte 0; 0x0005..7 bytes 1..3
//   write 0x0000 : push d_in to TX (zero bytes are ignored)
//   write 0x0004 : set program_done_out, push 0x00 to TX
// Handshake rule for both byte streams: a byte moves on a rising edge where
// valid and ready are both high; ready/valid never depend on the partner.
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] a_in,
    input  logic        wr_in,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        io_buffer_full,
    input  logic        rx_valid_in,
    input  logic [7:0]  rx_data_in,
    output logic        rx_ready_out,
    output logic        tx_valid_out,
    output logic [7:0]  tx_data_out,
    input  logic        tx_ready_in,
    output logic        program_done_out,
    output logic        tx_overflow_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ALMOST_C = CW'(FIFO_DEPTH - 2);

    // Address bits above the decoded range carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^a_in[31:18];

    // Storage
    logic [7:0] ram    [0:(1 << RAM_ADDR_W) - 1];
    logic [7:0] tx_mem [0:FIFO_DEPTH-1];
    logic [7:0] rx_mem [0:FIFO_DEPTH-1];

    logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] tx_count, rx_count;
    logic [31:0]   cycle_cnt;
    logic [31:0]   snapshot;

    // Decode
    logic        is_io;
    logic [15:0] io_off;
    logic        rd_rx;
    logic        wr_tx_data;
    logic        wr_done;
    logic        tx_push;
    logic [7:0]  tx_push_data;
    logic        tx_pop;
    logic        tx_full;
    logic        tx_accept;
    logic        tx_drop;
    logic        rx_push;
    logic        rx_pop;

    assign is_io        = (a_in[17:16] == 2'b11);
    assign io_off       = a_in[15:0];
    assign rd_rx        = !wr_in && is_io && (io_off == 16'h0000);
    assign wr_tx_data   = wr_in && is_io && (io_off == 16'h0000) && (d_in != 8'h00);
    assign wr_done      = wr_in && is_io && (io_off == 16'h0004);
    assign tx_push      = wr_tx_data || wr_done;
    assign tx_push_data = wr_done ? 8'h00 : d_in;

    assign tx_valid_out   = (tx_count != '0);
    assign tx_data_out    = tx_mem[tx_rd_ptr];
    assign tx_pop         = tx_valid_out && tx_ready_in;
    assign tx_full        = (tx_count == DEPTH_C);
    // A pop in the same cycle frees the slot the push lands in, even when full.
    assign tx_accept      = tx_push && (!tx_full || tx_pop);
    assign tx_drop        = tx_push && tx_full && !tx_pop;
    assign io_buffer_full = (tx_count >= ALMOST_C);

    // Ready is gated by reset so no byte is accepted while rst_in is low.
    assign rx_ready_out = rst_in && (rx_count != DEPTH_C);
    assign rx_push      = rx_valid_in && rx_ready_out;
    assign rx_pop       = rd_rx && (rx_count != '0);

    // Byte RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (wr_in && !is_io) begin
            ram[a_in[RAM_ADDR_W-1:0]] <= d_in;
        end
    end

    // FIFO storage writes; occupancy is tracked by the pointer block below.
    always_ff @(posedge clk_in) begin
        if (tx_accept) begin
            tx_mem[tx_wr_ptr] <= tx_push_data;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data_in;
        end
    end

    // FIFO pointers and counts; pointers wrap naturally modulo the depth.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (tx_accept) tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)    tx_rd_ptr <= tx_rd_ptr + PW'(1);
            tx_count <= tx_count + CW'(tx_accept) - CW'(tx_pop);
            if (rx_push)   rx_wr_ptr <= rx_wr_ptr + PW'(1);
            if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + PW'(1);
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // Read data, cycle counter, snapshot and sticky flags.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            d_out            <= 8'h00;
            cycle_cnt        <= 32'd0;
            snapshot         <= 32'd0;
            program_done_out <= 1'b0;
            tx_overflow_out  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_in) begin
                d_out <= 8'h00;
            end else if (!is_io) begin
                d_out <= ram[a_in[RAM_ADDR_W-1:0]];
            end else begin
                unique case (io_off)
                    16'h0000: d_out <= rx_pop ? rx_mem[rx_rd_ptr] : 8'h00;
                    16'h0004: begin
                        snapshot <= cycle_cnt;
                        d_out    <= cycle_cnt[7:0];
                    end
                    16'h0005: d_out <= snapshot[15:8];
                    16'h0006: d_out <= snapshot[23:16];
                    16'h0007: d_out <= snapshot[31:24];
                    default:  d_out <= 8'h00;
                endcase
            end
            if (wr_done) program_done_out <= 1'b1;
            if (tx_drop) tx_overflow_out  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus a randomized phase, all
// checked against a queue/array reference model of the responder's rules.
module tb_mem_io_responder;

    localparam int DEPTH = 8;
    localparam logic [31:0] IDLE_A = 32'h0003_0008;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] a_in = IDLE_A;
    logic        wr_in = 1'b0;
    logic [7:0]  d_in = 8'h00;
    logic [7:0]  d_out;
    logic        io_buffer_full;
    logic        rx_valid_in = 1'b0;
    logic [7:0]  rx_data_in = 8'h00;
    logic        rx_ready_out;
    logic        tx_valid_out;
    logic [7:0]  tx_data_out;
    logic        tx_ready_in = 1'b0;
    logic        program_done_out;
    logic        tx_overflow_out;

    mem_io_responder dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .a_in             (a_in),
        .wr_in            (wr_in),
        .d_in             (d_in),
        .d_out            (d_out),
        .io_buffer_full   (io_buffer_full),
        .rx_valid_in      (rx_valid_in),
        .rx_data_in       (rx_data_in),
        .rx_ready_out     (rx_ready_out),
        .tx_valid_out     (tx_valid_out),
        .tx_data_out      (tx_data_out),
        .tx_ready_in      (tx_ready_in),
        .program_done_out (program_done_out),
        .tx_overflow_out  (tx_overflow_out)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    // Reference model state
    int          tests = 0;
    int          failed = 0;
    logic [7:0]  ram_m [int];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [31:0] cnt_m = 32'd0;
    logic [31:0] snap_m = 32'd0;
    logic        done_m = 1'b0;
    logic        ovf_m = 1'b0;
    logic [31:0] pool [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Hold reset for some cycles with handshakes offered on both sides.
    task automatic do_reset(input int cycles);
        rst_in = 1'b0;
        a_in = IDLE_A; wr_in = 1'b0; d_in = 8'h00;
        rx_valid_in = 1'b1; rx_data_in = 8'hEE; tx_ready_in = 1'b1;
        #1;
        tx_q.delete(); rx_q.delete();
        cnt_m = 32'd0; snap_m = 32'd0; done_m = 1'b0; ovf_m = 1'b0;
        repeat (cycles) begin
            chk("rst_d_out", d_out, 8'h00);
            chk("rst_tx_valid", tx_valid_out, 1'b0);
            chk("rst_rx_ready", rx_ready_out, 1'b0);
            chk("rst_buf_full", io_buffer_full, 1'b0);
            chk("rst_prog_done", program_done_out, 1'b0);
            chk("rst_tx_ovf", tx_overflow_out, 1'b0);
            @(posedge clk_in); #1;
        end
        rst_in = 1'b1;
        rx_valid_in = 1'b0;
        tx_ready_in = 1'b0;
    endtask

    // One bus cycle: drive, check pre-edge outputs, advance model, check after edge.
    task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic rxv, input logic [7:0] rxd, input logic txr);
        logic        io;
        logic [15:0] off;
        int          idx;
        logic        rx_ok;
        logic [7:0]  e;
        a_in = a; wr_in = wr; d_in = d;
        rx_valid_in = rxv; rx_data_in = rxd; tx_ready_in = txr;
        #1;
        chk("tx_valid", tx_valid_out, tx_q.size() > 0);
        if (tx_q.size() > 0) chk("tx_data", tx_data_out, tx_q[0]);
        chk("rx_ready", rx_ready_out, rx_q.size() < DEPTH);
        chk("buf_full", io_buffer_full, tx_q.size() >= DEPTH - 2);
        io    = (a[17:16] == 2'b11);
        off   = a[15:0];
        idx   = int'(a[16:0]);
        rx_ok = rxv && (rx_q.size() < DEPTH);
        e     = 8'h00;
        if (!wr) begin
            if (!io) begin
                e = ram_m[idx];
            end else begin
                case (off)
                    16'h0000: if (rx_q.size() > 0) e = rx_q.pop_front();
                    16'h0004: begin snap_m = cnt_m; e = cnt_m[7:0]; end
                    16'h0005: e = snap_m[15:8];
                    16'h0006: e = snap_m[23:16];
                    16'h0007: e = snap_m[31:24];
                    default:  e = 8'h00;
                endcase
            end
        end
        if (txr && tx_q.size() > 0) void'(tx_q.pop_front());
        if (wr && io && ((off == 16'h0000 && d != 8'h00) || off == 16'h0004)) begin
            if (tx_q.size() < DEPTH) tx_q.push_back((off == 16'h0004) ? 8'h00 : d);
            else ovf_m = 1'b1;
            if (off == 16'h0004) done_m = 1'b1;
        end
        if (rx_ok) rx_q.push_back(rxd);
        if (wr && !io) ram_m[idx] = d;
        cnt_m = cnt_m + 32'd1;
        @(posedge clk_in); #1;
        chk("d_out", d_out, e);
        chk("prog_done", program_done_out, done_m);
        chk("tx_ovf", tx_overflow_out, ovf_m);
    endtask

    task automatic idle(input logic txr);
        step(IDLE_A, 1'b0, 8'h00, 1'b0, 8'h00, txr);
    endtask

    // Stimulus
    initial begin
        logic [31:0] a;
        logic [7:0]  d;
        int          r;
        pool = '{32'h0000_0000, 32'h0000_0010, 32'h0001_FFFF, 32'h0001_0000,
                 32'h0002_ABCD, 32'h0000_0123, 32'h0000_F0F0, 32'h0000_1234};
        #2;
        do_reset(3);

        // RAM write then read, and read data cleared after a write
        step(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
        chk("after_write_zero", d_out, 8'h00);
        step(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("ram_rd_a5", d_out, 8'hA5);
        step(32'hFFFC_0010, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
        step(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("raw_new_data", d_out, 8'h3C);

        // TX writes with a zero byte skipped, then drain
        step(32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
        step(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        step(32'h0003_0000, 1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
        chk("tx_head_41", tx_data_out, 8'h41);
        chk("tx_two_not_full", io_buffer_full, 1'b0);
        idle(1'b1);
        chk("tx_head_42", tx_data_out, 8'h42);
        idle(1'b1);
        chk("tx_drained", tx_valid_out, 1'b0);

        // Fill TX: almost-full from 6, full push+pop, then a dropped push
        for (int i = 1; i <= 8; i++) begin
            step(32'h0003_0000, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
            chk("buf_full_level", io_buffer_full, i >= 6);
        end
        step(32'h0003_0000, 1'b1, 8'h09, 1'b0, 8'h00, 1'b1);
        chk("full_push_pop_no_ovf", tx_overflow_out, 1'b0);
        chk("full_push_pop_head", tx_data_out, 8'h02);
        step(32'h0003_0000, 1'b1, 8'h0A, 1'b0, 8'h00, 1'b0);
        chk("ovf_set", tx_overflow_out, 1'b1);
        repeat (9) idle(1'b1);

        // RX: push then two reads; simultaneous push with empty read
        step(IDLE_A, 1'b0, 8'h00, 1'b1, 8'h31, 1'b0);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("rx_rd_31", d_out, 8'h31);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("rx_rd_empty", d_out, 8'h00);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        chk("rx_push_pop_empty", d_out, 8'h00);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("rx_rd_77", d_out, 8'h77);
        for (int i = 0; i < 9; i++) step(IDLE_A, 1'b0, 8'h00, 1'b1, 8'(8'h50 + i), 1'b0);
        chk("rx_full_not_ready", rx_ready_out, 1'b0);
        for (int i = 0; i < 9; i++) step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Cycle counter snapshot 100 cycles after reset
        do_reset(2);
        repeat (100) idle(1'b0);
        step(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("snap_b0_100", d_out, 32'd100);
        step(32'h0003_0005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("snap_b1", d_out, 8'h00);
        step(32'h0003_0006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("snap_b2", d_out, 8'h00);
        step(32'h0003_0007, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("snap_b3", d_out, 8'h00);

        // Randomized mix against the model
        for (int i = 0; i < 8; i++) step(pool[i], 1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            a = $urandom & 32'hFFFC_0000;
            d = 8'($urandom);
            case (r)
                0, 1: begin a = (a & 32'hFFFC_0000) | pool[$urandom_range(0, 7)]; end
                2, 3: begin a = (a & 32'hFFFC_0000) | pool[$urandom_range(0, 7)]; end
                4:    a = a | 32'h0003_0000;
                5:    a = a | (32'h0003_0004 + 32'($urandom_range(0, 3)));
                6:    begin a = a | 32'h0003_0000; if ($urandom_range(0, 3) == 0) d = 8'h00; end
                7:    begin a = a | 32'h0003_0000; if (d == 8'h00) d = 8'h01; end
                8:    a = a | (($urandom_range(0, 1) == 0) ? 32'h0003_0008 : 32'h0003_FF00);
                default: a = a | 32'h0003_0010;
            endcase
            step(a, (r == 0 || r == 1 || r == 6 || r == 7 || r == 9), d,
                 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0));
        end

        // Program done, then reset mid-transfer; RAM keeps its data
        repeat (10) idle(1'b1);
        step(32'h0000_0100, 1'b1, 8'h5C, 1'b0, 8'h00, 1'b0);
        step(32'h0003_0004, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
        chk("prog_done_set", program_done_out, 1'b1);
        chk("done_tx_valid", tx_valid_out, 1'b1);
        chk("done_tx_zero", tx_data_out, 8'h00);
        step(32'h0003_0000, 1'b1, 8'h61, 1'b1, 8'h12, 1'b0);
        do_reset(2);
        chk("post_rst_done", program_done_out, 1'b0);
        chk("post_rst_tx_valid", tx_valid_out, 1'b0);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("post_rst_rx_empty", d_out, 8'h00);
        step(32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("ram_retained", d_out, 8'h5C);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
